// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// buffers {pc, instr} pairs in a small FIFO and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] buf_pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc_d    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_d [FIFO_DEPTH];
    logic                  pop;
    logic                  push;

    // During a redirect the head is wrong-path, so it is masked rather than offered.
    assign valid_o     = (count_q != '0) && !redirect_i;
    assign pc_o        = buf_pc_q[rd_ptr_q];
    assign instr_o     = buf_instr_q[rd_ptr_q];
    assign imem_addr_o = fetch_pc_q;

    assign pop  = valid_o && ready_i;
    assign push = !redirect_i && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = fetch_pc_q;
                buf_instr_d[wr_ptr_q] = imem_instr_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + DATA_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a wrapping-PC instance and a
// randomized run against a queue-based model of the fetch buffer.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr, redirect_pc, instr, pc;
    logic        redirect, valid, ready;
    logic [31:0] imem_addr2, imem_instr2, instr2, pc2;
    logic        valid2;
    logic        ready2    = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory image: word n holds n+1.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem_instr2 = mem_word(imem_addr2);

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_o(instr),
        .pc_o(pc), .valid_o(valid), .ready_i(ready)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr_o(imem_addr2), .imem_instr_i(imem_instr2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2), .instr_o(instr2),
        .pc_o(pc2), .valid_o(valid2), .ready_i(ready2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic [31:0] ea;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rp; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ea = ea;
        return v;
    endfunction

    vec_t vecs[28];

    // Reference model: buffered entries in order, plus the next fetch address.
    logic [31:0] exp_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;

    task automatic model_check_and_step(input logic rd, input logic [31:0] rp, input logic rdy);
        logic m_valid;
        logic can_push;
        m_valid = (exp_q.size() != 0) && !rd;
        check("rand_valid", {31'b0, valid}, {31'b0, m_valid});
        check("rand_addr", imem_addr, model_pc);
        if (m_valid) begin
            check("rand_pc", pc, exp_q[0]);
            check("rand_instr", instr, exp_instr_q[0]);
        end
        if (rd) begin
            exp_q.delete();
            exp_instr_q.delete();
            model_pc = {rp[31:2], 2'b00};
        end else begin
            can_push = (exp_q.size() < 2) || (m_valid && rdy);
            if (m_valid && rdy) begin
                void'(exp_q.pop_front());
                void'(exp_instr_q.pop_front());
            end
            if (can_push) begin
                exp_q.push_back(model_pc);
                exp_instr_q.push_back(mem_word(model_pc));
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        rst = r; redirect = rd; redirect_pc = rp; ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        vecs[0]  = mk(1, 0, 0,     1, 0, 32'h0,   32'h0,  32'h0);
        vecs[1]  = mk(0, 0, 0,     1, 0, 32'h0,   32'h0,  32'h0);
        vecs[2]  = mk(0, 0, 0,     1, 1, 32'h0,   32'h1,  32'h4);
        vecs[3]  = mk(0, 0, 0,     1, 1, 32'h4,   32'h2,  32'h8);
        vecs[4]  = mk(0, 0, 0,     1, 1, 32'h8,   32'h3,  32'hC);
        vecs[5]  = mk(0, 0, 0,     1, 1, 32'hC,   32'h4,  32'h10);
        vecs[6]  = mk(1, 0, 0,     0, 0, 32'h0,   32'h0,  32'h0);
        vecs[7]  = mk(0, 0, 0,     0, 0, 32'h0,   32'h0,  32'h0);
        vecs[8]  = mk(0, 0, 0,     0, 1, 32'h0,   32'h1,  32'h4);
        vecs[9]  = mk(0, 0, 0,     0, 1, 32'h0,   32'h1,  32'h8);
        vecs[10] = mk(0, 0, 0,     0, 1, 32'h0,   32'h1,  32'h8);
        vecs[11] = mk(0, 0, 0,     0, 1, 32'h0,   32'h1,  32'h8);
        vecs[12] = mk(0, 0, 0,     0, 1, 32'h0,   32'h1,  32'h8);
        vecs[13] = mk(0, 0, 0,     1, 1, 32'h0,   32'h1,  32'h8);
        vecs[14] = mk(0, 0, 0,     1, 1, 32'h4,   32'h2,  32'hC);
        vecs[15] = mk(0, 1, 32'h43, 1, 0, 32'h0,  32'h0,  32'h10);
        vecs[16] = mk(0, 0, 0,     1, 0, 32'h0,   32'h0,  32'h40);
        vecs[17] = mk(0, 0, 0,     1, 1, 32'h40,  32'h11, 32'h44);
        vecs[18] = mk(0, 0, 0,     1, 1, 32'h44,  32'h12, 32'h48);
        vecs[19] = mk(0, 0, 0,     0, 1, 32'h48,  32'h13, 32'h4C);
        vecs[20] = mk(0, 0, 0,     0, 1, 32'h48,  32'h13, 32'h50);
        vecs[21] = mk(0, 1, 32'h100, 0, 0, 32'h0, 32'h0,  32'h50);
        vecs[22] = mk(0, 0, 0,     1, 0, 32'h0,   32'h0,  32'h100);
        vecs[23] = mk(0, 0, 0,     1, 1, 32'h100, 32'h41, 32'h104);
        vecs[24] = mk(0, 0, 0,     0, 1, 32'h104, 32'h42, 32'h108);
        vecs[25] = mk(1, 0, 0,     0, 0, 32'h0,   32'h0,  32'h0);
        vecs[26] = mk(0, 0, 0,     1, 0, 32'h0,   32'h0,  32'h0);
        vecs[27] = mk(0, 0, 0,     1, 1, 32'h0,   32'h1,  32'h4);

        repeat (2) next_cycle();

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].ev});
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].ea);
            if (vecs[i].ev || vecs[i].rst) begin
                check($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
                check($sformatf("vec%0d_instr", i), instr, vecs[i].ei);
            end
            next_cycle();
        end

        // Wrapping PC instance: FFFF_FFF8, FFFF_FFFC, 0, 4 delivered back to back.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("wrap_valid0", {31'b0, valid2}, 32'h0);
        check("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * c);
            @(negedge clk);
            check($sformatf("wrap_valid%0d", c + 1), {31'b0, valid2}, 32'h1);
            check($sformatf("wrap_pc%0d", c + 1), pc2, exp_pc);
            check($sformatf("wrap_instr%0d", c + 1), instr2, mem_word(exp_pc));
            next_cycle();
        end

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        exp_q.delete();
        exp_instr_q.delete();
        model_pc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic        rd;
            logic [31:0] rp;
            logic        rdy;
            rd  = ($urandom_range(0, 9) == 0);
            rp  = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            drive(1'b0, rd, rp, rdy);
            @(negedge clk);
            model_check_and_step(rd, rp, rdy);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the instruction memory and downstream-feeding decode. Owns the program counter and drives the word address into the combinational-read instruction memory. Captures the returned instruction word with its PC into a small FIFO and presents it to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) from execute that flushes wrong-path entries.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
FIFO_DEPTH, 2, entries in the fetch buffer; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
imem_addr_o  output  DATA_WIDTH  byte address to instruction memory (always word aligned)
imem_instr_i  input  DATA_WIDTH  instruction word, valid combinationally in same cycle as imem_addr_o
redirect_i  input  1  redirect request from execute
redirect_pc_i  input  DATA_WIDTH  redirect target; bits [1:0] ignored
instr_o  output  DATA_WIDTH  instruction at FIFO head
pc_o  output  DATA_WIDTH  PC of instr_o
valid_o  output  1  instr_o/pc_o valid
ready_i  input  1  decode accepts head this cycle

Behaviour:
- Reset (async, active-high): fetch_pc = RESET_PC, count = 0, rd/wr pointers = 0, all FIFO storage = 0; hence valid_o = 0, instr_o = 0, pc_o = 0, imem_addr_o = RESET_PC.
- imem_addr_o = fetch_pc (registered, with bits [1:0] always 0).
- pop = valid_o && ready_i. valid_o = (count != 0) && !redirect_i (combinational mask: head is wrong-path during a redirect cycle).
- push = !redirect_i && (count < FIFO_DEPTH || pop). On push: write {fetch_pc, imem_instr_i} at wr pointer, fetch_pc <= fetch_pc + 4.
- Full and pop in same cycle: pop and push both occur, count unchanged. Full and no pop: no push, fetch_pc holds, imem_addr_o holds.
- Empty: no pop possible; push still occurs, so valid_o rises the cycle after the first fetch.
- Redirect (highest priority): count <= 0, pointers reset to 0, fetch_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}; no push, no pop that cycle regardless of ready_i. First target instruction pushed next cycle, visible on valid_o the cycle after that (redirect-to-valid latency = 2 cycles).
- Latency: fetch-to-valid 1 cycle; sustained throughput 1 instr/cycle with ready_i held high.
- PC arithmetic modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- pc_o/instr_o stable while valid_o && !ready_i (no head change without pop or redirect).
- Reset mid-stream: all state returns to reset values immediately (async); buffered entries discarded.
- count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, ready_i=1, memory word n = n+1: valid_o rises cycle 1; stream pc_o 0,4,8,12 with instr_o 1,2,3,4, one per cycle, no gaps.
- ready_i=0 for 5 cycles after first fetch: count reaches 2, imem_addr_o freezes at 8, head stays pc 0; ready_i=1 then delivers pc 0,4,8 with no loss or duplicate.
- Redirect with head pc 8 valid, redirect_pc_i=0x43: valid_o=0 that cycle, pc 8 never accepted even with ready_i=1; imem_addr_o=0x40 next cycle; pc_o=0x40 valid two cycles after redirect.
- Redirect while FIFO full and ready_i=0: both entries discarded, count=0, next delivered pc is target.
- RESET_PC=32'hFFFF_FFF8: pc_o sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
- Assert rst for 1 cycle mid-stream (count=2): valid_o drops immediately, fetch restarts at RESET_PC, first post-reset pc_o = RESET_PC.
